// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: state encodings
// and the bundle widths used by the EX/MEM and MEM/WB instances.
// Optional feature macro: PIPE_STALL_CNT_EN (adds the stall_count port).
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam int EXMEM_DATA_W = 101;
    localparam int EXMEM_CTRL_W = 5;
    localparam int MEMWB_DATA_W = 71;
    localparam int MEMWB_CTRL_W = 2;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: a data+control register with a load enable.
// Contents only change on en_i; reset clears to zero asynchronously.
module pipe_entry_reg #(
    parameter int W = 106
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    // Load on enable, hold otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     q_q <= '0;
        else if (en_i) q_q <= d_i;
    end

    assign q_o = q_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid.
// in_ready depends only on registered state, so there is no combinational
// path from out_ready to in_ready. Control bits are masked when the stage
// is empty so write-enable style bits cannot fire on a bubble.
// Optional feature macro: PIPE_STALL_CNT_EN (saturating stall counter).
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = EXMEM_DATA_W,
    parameter int CTRL_W = EXMEM_CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STALL_CNT_EN
   ,output logic [CNT_W-1:0]  stall_count
`endif
);

    localparam int W = DATA_W + CTRL_W;

    logic [1:0]   state_q, state_d;
    logic         acc, pop;
    logic         main_en, skid_en, main_from_skid;
    logic [W-1:0] in_bundle, main_d, main_q, skid_q;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q == ST_BUSY) || (state_q == ST_FULL);
    assign acc       = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign in_bundle = {in_data, in_ctrl};
    assign main_d    = main_from_skid ? skid_q : in_bundle;

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    // Next state and entry load enables; flush overrides everything and
    // suppresses loads so a bundle offered during flush is dropped.
    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_BUSY: begin
                    if (acc && pop) begin
                        main_en = 1'b1;
                    end else if (acc) begin
                        skid_en = 1'b1;
                        state_d = ST_FULL;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = ST_BUSY;
                    end
                end
                // EMPTY, and the unused encoding behaves like EMPTY.
                default: begin
                    if (acc) begin
                        main_en = 1'b1;
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            endcase
        end
    end

    pipe_entry_reg #(.W(W)) u_main (
        .clk_i (Clk),
        .rst_i (Rst),
        .en_i  (main_en),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    pipe_entry_reg #(.W(W)) u_skid (
        .clk_i (Clk),
        .rst_i (Rst),
        .en_i  (skid_en),
        .d_i   (in_bundle),
        .q_o   (skid_q)
    );

    assign out_data = main_q[W-1:CTRL_W];
    assign out_ctrl = main_q[CTRL_W-1:0] & {CTRL_W{out_valid}};

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    // Count cycles where a held bundle is refused downstream; saturates,
    // and only reset clears it so flushes do not hide stall history.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)                                       stall_q <= '0;
        else if (out_valid && !out_ready && stall_q != '1) stall_q <= stall_q + 1'b1;
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage. The reference model is a
// capacity-2 queue plus the last bundle that reached the head.
// Optional feature macro: PIPE_STALL_CNT_EN (enables stall counter tests).
module tb_pipe_skid_stage;

    localparam int DATA_W = 101;
    localparam int CTRL_W = 5;
    localparam int CNT_W  = 4;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic              in_ready, out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_count;
`endif

    int checks = 0;
    int failures = 0;

    // reference model
    logic [DATA_W-1:0] mq_d[$];
    logic [CTRL_W-1:0] mq_c[$];
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    int                m_stall;

    pipe_skid_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
`ifdef PIPE_STALL_CNT_EN
       ,.stall_count (stall_count)
`endif
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        mq_d.delete();
        mq_c.delete();
        m_data  = '0;
        m_ctrl  = '0;
        m_stall = 0;
    endtask

    // One clock: apply handshake rules to the model, then sample #1 later.
    task automatic tick();
        bit acc, pop;
        acc = in_valid && (mq_d.size() < 2);
        pop = (mq_d.size() > 0) && out_ready;
        if (mq_d.size() > 0 && !out_ready && m_stall < SAT) m_stall++;
        @(posedge Clk);
        if (flush) begin
            mq_d.delete();
            mq_c.delete();
        end else begin
            if (pop) begin
                void'(mq_d.pop_front());
                void'(mq_c.pop_front());
            end
            if (acc) begin
                mq_d.push_back(in_data);
                mq_c.push_back(in_ctrl);
            end
        end
        if (mq_d.size() > 0) begin
            m_data = mq_d[0];
            m_ctrl = mq_c[0];
        end
        #1;
    endtask

    // Synchronised reset pulse between edges.
    task automatic do_reset();
        Rst = 1'b1;
        model_reset();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #2;
        Rst = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[DATA_W-1:0];
    endfunction

    task automatic test_reset();
        model_reset();
        Rst = 1'b1; in_valid = 1'b1; in_data = DATA_W'(8'hAB); in_ctrl = 5'b00011;
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (out_ctrl !== '0) begin failures++; $display("FAIL reset_out_ctrl: got %0h expected 0", out_ctrl); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
        Rst = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++; if (out_data !== DATA_W'(8'hAB)) begin failures++; $display("FAIL post_reset_data: got %0h expected ab", out_data); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL post_reset_valid: got %0b expected 1", out_valid); end
        checks++; if (out_ctrl !== 5'b00011) begin failures++; $display("FAIL post_reset_ctrl: got %0h expected 3", out_ctrl); end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = DATA_W'(i); in_ctrl = CTRL_W'(i);
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready %0d: got %0b expected 1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== DATA_W'(i)) begin
                failures++; $display("FAIL stream_out %0d: got v=%0b d=%0h expected v=1 d=%0h", i, out_valid, out_data, i);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== DATA_W'(4)) begin
            failures++; $display("FAIL stream_drain: got v=%0b d=%0h expected v=0 d=4", out_valid, out_data);
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] got[$];
        bool_loop: begin end
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = DATA_W'(5); tick();
        in_data = DATA_W'(6); tick();
        in_data = DATA_W'(7); tick();
        checks++; if (out_data !== DATA_W'(5)) begin failures++; $display("FAIL bp_hold: got %0h expected 5", out_data); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %0b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: got %0b expected 1", out_valid); end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bit took;
            if (out_valid && out_ready) got.push_back(out_data);
            took = in_valid && in_ready;
            tick();
            if (took) in_valid = 1'b0;
        end
        checks++; if (got.size() != 3 || got[0] !== DATA_W'(5) || got[1] !== DATA_W'(6) || got[2] !== DATA_W'(7)) begin
            failures++; $display("FAIL bp_order: got %0d items expected 5,6,7", got.size());
        end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 5'b10101;
        in_data = DATA_W'(8'h11); tick();
        in_data = DATA_W'(8'h22); tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_prefull: got %0b expected 0", in_ready); end
        flush = 1'b1; in_data = DATA_W'(16'hDEAD); tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %0b expected 0", out_valid); end
        checks++; if (out_ctrl !== '0) begin failures++; $display("FAIL flush_ctrl: got %0h expected 0", out_ctrl); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready: got %0b expected 1", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_ghost %0d: got v=%0b d=%0h expected v=0", c, out_valid, out_data); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = DATA_W'(8'h5A); in_ctrl = 5'b11111; tick();
        in_valid = 1'b0;
        #2;
        Rst = 1'b1;
        model_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_valid: got %0b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL async_data: got %0h expected 0", out_data); end
        checks++; if (out_ctrl !== '0) begin failures++; $display("FAIL async_ctrl: got %0h expected 0", out_ctrl); end
        #1;
        Rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 11) == 0);
            in_data   = rand_data();
            in_ctrl   = r[CTRL_W-1:0];
            tick();
            checks++;
            if (out_valid !== (mq_d.size() > 0) || in_ready !== (mq_d.size() < 2) ||
                out_data !== m_data || out_ctrl !== (out_valid ? m_ctrl : CTRL_W'(0))) begin
                failures++;
                $display("FAIL random cyc %0d: got v=%0b r=%0b d=%0h c=%0h expected v=%0b r=%0b d=%0h c=%0h",
                         c, out_valid, in_ready, out_data, out_ctrl,
                         mq_d.size() > 0, mq_d.size() < 2, m_data, (mq_d.size() > 0) ? m_ctrl : CTRL_W'(0));
            end
`ifdef PIPE_STALL_CNT_EN
            checks++; if (stall_count !== CNT_W'(m_stall)) begin
                failures++; $display("FAIL random_stall cyc %0d: got %0d expected %0d", c, stall_count, m_stall);
            end
`endif
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

`ifdef PIPE_STALL_CNT_EN
    task automatic test_stall_count();
        do_reset();
        in_valid = 1'b1; in_data = DATA_W'(1); tick();
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (10) tick();
        checks++; if (stall_count !== CNT_W'(10)) begin failures++; $display("FAIL stall_10: got %0d expected 10", stall_count); end
        flush = 1'b1; out_ready = 1'b1; tick();
        flush = 1'b0;
        checks++; if (stall_count !== CNT_W'(10)) begin failures++; $display("FAIL stall_flush: got %0d expected 10", stall_count); end
        in_valid = 1'b1; tick();
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (20) tick();
        checks++; if (stall_count !== CNT_W'(SAT)) begin failures++; $display("FAIL stall_sat: got %0d expected %0d", stall_count, SAT); end
        out_ready = 1'b1; tick();
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
`ifdef PIPE_STALL_CNT_EN
        test_stall_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
